referee_mux: RTL

- Return-path arbiter for the transaction layer. Merges four class FIFOs (classes 0..3) into one output FIFO.
- Pops the head word from one non-empty class FIFO and pushes it, unchanged, into the shared output FIFO.
- Sits between the four class FIFOs and the single egress FIFO, and is gated by the same one-hot layer state bus as the class demultiplexer.

---
 rtl/referee_mux.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/referee_mux.sv
// Purpose: return-path arbiter; moves one head word from a non-empty class FIFO into the egress FIFO.
// Latency: 1 cycle from the sampling edge to push/pop; one word at most every 3 cycles (WAIT, GRANT, GAP).
// Backpressure: almost_full_out is sampled only in WAIT; a word already granted always completes.
// Build option: define REFEREE_MUX_RR_EN for round-robin arbitration (default is fixed priority 3 > 2 > 1 > 0).

module referee_mux #(
    parameter int DATA_WIDTH = 12,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic [3:0]            state,
    input  logic [DATA_WIDTH-1:0] data_in_0,
    input  logic [DATA_WIDTH-1:0] data_in_1,
    input  logic [DATA_WIDTH-1:0] data_in_2,
    input  logic [DATA_WIDTH-1:0] data_in_3,
    input  logic                  empty_0,
    input  logic                  empty_1,
    input  logic                  empty_2,
    input  logic                  empty_3,
    input  logic                  almost_full_out,
    output logic                  pop_0,
    output logic                  pop_1,
    output logic                  pop_2,
    output logic                  pop_3,
    output logic                  push,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [1:0]            grant_id,
    output logic [CNT_WIDTH-1:0]  words_sent
);

    // One-hot layer states shared with the class demultiplexer.
    localparam logic [3:0] LAYER_RESET  = 4'b0001;
    localparam logic [3:0] LAYER_IDLE   = 4'b0100;
    localparam logic [3:0] LAYER_ACTIVE = 4'b1000;

    typedef enum logic [1:0] {
        FSM_WAIT  = 2'd0,
        FSM_GRANT = 2'd1,
        FSM_GAP   = 2'd2
    } fsm_t;

    fsm_t                  fsm_q, fsm_d;
    logic [3:0]            pop_q, pop_d;
    logic                  push_q, push_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [1:0]            grant_id_q, grant_id_d;
    logic [CNT_WIDTH-1:0]  words_sent_q, words_sent_d;

    logic                  layer_reset;
    logic                  layer_en;
    logic [3:0]            not_empty;
    logic                  any_ready;
    logic [1:0]            sel_cls;
    logic [DATA_WIDTH-1:0] sel_word;

`ifdef REFEREE_MUX_RR_EN
    // Last granted class; the next search starts one past it.
    logic [1:0]            rr_ptr_q, rr_ptr_d;
`endif

    assign layer_reset = (state == LAYER_RESET);
    assign layer_en    = (state == LAYER_IDLE) || (state == LAYER_ACTIVE);
    assign not_empty   = ~{empty_3, empty_2, empty_1, empty_0};
    assign any_ready   = |not_empty;

`ifdef REFEREE_MUX_RR_EN
    // Round-robin pick: scan pointer+1, +2, +3, +4 (mod 4) and take the first non-empty class.
    always_comb begin
        logic       found;
        logic [1:0] cand;
        sel_cls = 2'd0;
        found   = 1'b0;
        cand    = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            cand = rr_ptr_q + 2'(i);
            if (!found && not_empty[cand]) begin
                sel_cls = cand;
                found   = 1'b1;
            end
        end
    end
`else
    // Fixed-priority pick: class 3 wins over 2, 2 over 1, 1 over 0.
    always_comb begin
        sel_cls = 2'd0;
        if (not_empty[3]) begin
            sel_cls = 2'd3;
        end else if (not_empty[2]) begin
            sel_cls = 2'd2;
        end else if (not_empty[1]) begin
            sel_cls = 2'd1;
        end else begin
            sel_cls = 2'd0;
        end
    end
`endif

    // Head-word mux; the class bits in the top of the word pass through untouched.
    always_comb begin
        sel_word = data_in_0;
        case (sel_cls)
            2'd0:    sel_word = data_in_0;
            2'd1:    sel_word = data_in_1;
            2'd2:    sel_word = data_in_2;
            2'd3:    sel_word = data_in_3;
            default: sel_word = data_in_0;
        endcase
    end

    // Next-state and registered-output logic for the WAIT/GRANT/GAP sequence.
    always_comb begin
        fsm_d        = fsm_q;
        pop_d        = 4'b0000;
        push_d       = 1'b0;
        data_out_d   = '0;
        grant_id_d   = grant_id_q;
        words_sent_d = words_sent_q;
`ifdef REFEREE_MUX_RR_EN
        rr_ptr_d     = rr_ptr_q;
`endif

        // The strobes were high for the whole GRANT cycle, so the word has been
        // transferred by this edge whatever the layer state does now.
        if (fsm_q == FSM_GRANT) begin
            words_sent_d = words_sent_q + CNT_WIDTH'(1);
        end

        if (layer_reset) begin
            // Layer-level reset behaves exactly like the pin reset, but at the edge.
            fsm_d        = FSM_WAIT;
            grant_id_d   = 2'd0;
            words_sent_d = '0;
`ifdef REFEREE_MUX_RR_EN
            rr_ptr_d     = 2'd0;
`endif
        end else if (!layer_en) begin
            // Outside IDLE/ACTIVE nothing is granted; counter and last grant are kept.
            fsm_d = FSM_WAIT;
        end else begin
            case (fsm_q)
                FSM_WAIT: begin
                    if (!almost_full_out && any_ready) begin
                        pop_d[sel_cls] = 1'b1;
                        push_d         = 1'b1;
                        data_out_d     = sel_word;
                        grant_id_d     = sel_cls;
`ifdef REFEREE_MUX_RR_EN
                        rr_ptr_d       = sel_cls;
`endif
                        fsm_d          = FSM_GRANT;
                    end
                end
                FSM_GRANT: begin
                    // Strobes drop; the popped FIFO's flags need a cycle to settle.
                    fsm_d = FSM_GAP;
                end
                FSM_GAP: begin
                    fsm_d = FSM_WAIT;
                end
                default: begin
                    fsm_d = FSM_WAIT;
                end
            endcase
        end
    end

    // State and output registers; pin reset clears everything immediately.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            fsm_q        <= FSM_WAIT;
            pop_q        <= 4'b0000;
            push_q       <= 1'b0;
            data_out_q   <= '0;
            grant_id_q   <= 2'd0;
            words_sent_q <= '0;
        end else begin
            fsm_q        <= fsm_d;
            pop_q        <= pop_d;
            push_q       <= push_d;
            data_out_q   <= data_out_d;
            grant_id_q   <= grant_id_d;
            words_sent_q <= words_sent_d;
        end
    end

`ifdef REFEREE_MUX_RR_EN
    // Round-robin pointer register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            rr_ptr_q <= 2'd0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    assign pop_0      = pop_q[0];
    assign pop_1      = pop_q[1];
    assign pop_2      = pop_q[2];
    assign pop_3      = pop_q[3];
    assign push       = push_q;
    assign data_out   = data_out_q;
    assign grant_id   = grant_id_q;
    assign words_sent = words_sent_q;

endmodule
